// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared UART constants and types.
// Holds the default FIFO geometry (depth, byte width, pointer/level widths) and the
// receive-ack handshake state type. Intended for reuse by a future TX FIFO.
package uart_rx_fifo_pkg;

    parameter int unsigned UART_DEPTH_LOG2 = 4;
    parameter int unsigned UART_DATA_W     = 8;
    parameter int unsigned UART_DEPTH      = 1 << UART_DEPTH_LOG2;
    parameter int unsigned UART_PTR_W      = UART_DEPTH_LOG2;
    parameter int unsigned UART_LVL_W      = UART_DEPTH_LOG2 + 1;

    // Handshake towards the receiver: StAck lasts exactly one cycle.
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StAck  = 1'b1
    } ack_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side handshake and CPU-side access bundle of the RX FIFO.
//   rx_data/rx_avail/rx_ack : sticky avail/ack handshake with uart_rx
//   pop/flush/clr_overrun   : CPU strobes
//   rd_data/non_empty/full/half_full/overrun/level : CPU-visible head byte and status
// Modport slave is the FIFO; modport master is whatever drives it (register file / bench).
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = UART_DEPTH_LOG2,
    parameter int unsigned DATA_W     = UART_DATA_W
);
    logic [DATA_W-1:0]   rx_data;
    logic                rx_avail;
    logic                rx_ack;
    logic                pop;
    logic                flush;
    logic                clr_overrun;
    logic [DATA_W-1:0]   rd_data;
    logic                non_empty;
    logic                full;
    logic                half_full;
    logic                overrun;
    logic [DEPTH_LOG2:0] level;

    modport slave (
        input  rx_data, rx_avail, pop, flush, clr_overrun,
        output rx_ack, rd_data, non_empty, full, half_full, overrun, level
    );

    modport master (
        output rx_data, rx_avail, pop, flush, clr_overrun,
        input  rx_ack, rd_data, non_empty, full, half_full, overrun, level
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: 2^DEPTH_LOG2 x DATA_W register array, one synchronous write port and
// one asynchronous read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address, wdata : write data
//   raddr : read address,  rdata : read data (combinational)
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = UART_DEPTH_LOG2,
    parameter int unsigned DATA_W     = UART_DATA_W
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO between uart_rx and the UART register file.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : uart_rx_fifo_if.slave (receiver handshake, CPU strobes, head byte, status)
// Captures one byte per rx_avail assertion, acks it with a one-cycle rx_ack pulse, and
// drops bytes (setting sticky overrun) when no slot is free.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = UART_DEPTH_LOG2,
    parameter int unsigned DATA_W     = UART_DATA_W
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    ack_state_e        ack_q, ack_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overrun_q, overrun_d;
    logic              capture;
    logic              full;
    logic              non_empty;
    logic              pop_ok;
    logic              push_ok;
    logic              drop;
    logic [DATA_W-1:0] head;

    // Ack handshake: the receiver still shows rx_avail while we ack, so StAck blocks a
    // second capture of the same byte.
    always_comb begin
        ack_d   = StIdle;
        capture = 1'b0;
        unique case (ack_q)
            StIdle: begin
                if (bus.rx_avail) begin
                    capture = 1'b1;
                    ack_d   = StAck;
                end
            end
            StAck:   ack_d = StIdle;
            default: ack_d = StIdle;
        endcase
    end

    assign full      = (level_q == LVL_W'(DEPTH));
    assign non_empty = (level_q != '0);

    // A pop frees the slot for a same-cycle capture even when full; flush cancels both.
    assign pop_ok  = bus.pop & non_empty & ~bus.flush;
    assign push_ok = capture & ~bus.flush & (~full | pop_ok);
    assign drop    = capture & ~bus.flush & full & ~pop_ok;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;
        if (bus.flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            overrun_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
            // A dropped byte wins over a same-cycle clear.
            if (drop) begin
                overrun_d = 1'b1;
            end else if (bus.clr_overrun) begin
                overrun_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q     <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (bus.rx_data),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    assign bus.rx_ack    = (ack_q == StAck);
    assign bus.rd_data   = non_empty ? head : '0;
    assign bus.non_empty = non_empty;
    assign bus.full      = full;
    assign bus.half_full = (level_q >= LVL_W'(DEPTH / 2));
    assign bus.overrun   = overrun_q;
    assign bus.level     = level_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo.
// A queue-based reference model tracks contents, overrun and the expected ack; a directed
// table, hand-written corner sequences and a randomized receiver/CPU run are all compared
// against it, and the directed parts also carry explicit expected constants.
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    localparam int DEPTH = UART_DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo_if bus ();

    uart_rx_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_ovr = 1'b0;
    bit         m_ack = 1'b0;

    typedef struct {
        logic       av;
        logic [7:0] d;
        logic       p;
        logic       f;
        logic       c;
        int         e_lvl;
        logic       e_ack;
        logic [7:0] e_rd;
        logic       e_ovr;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic av, input logic [7:0] d, input logic p,
                              input logic f, input logic c);
        bit cap;
        bit popv;
        bit dropped;
        cap     = av && !m_ack;
        popv    = p && (m_q.size() != 0) && !f;
        dropped = 1'b0;
        if (f) begin
            m_q.delete();
            m_ovr = 1'b0;
        end else begin
            if (popv) void'(m_q.pop_front());
            if (cap) begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else dropped = 1'b1;
            end
            if (dropped) m_ovr = 1'b1;
            else if (c) m_ovr = 1'b0;
        end
        m_ack = cap;
    endtask

    task automatic check_model();
        int sz;
        sz = m_q.size();
        chk("level", 32'(bus.level), 32'(sz));
        chk("non_empty", 32'(bus.non_empty), 32'(sz != 0));
        chk("full", 32'(bus.full), 32'(sz == DEPTH));
        chk("half_full", 32'(bus.half_full), 32'(sz >= DEPTH / 2));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
        chk("rx_ack", 32'(bus.rx_ack), 32'(m_ack));
        chk("rd_data", 32'(bus.rd_data), (sz != 0) ? 32'(m_q[0]) : 32'd0);
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic cycle(input logic av, input logic [7:0] d, input logic p,
                         input logic f, input logic c);
        bus.rx_avail    = av;
        bus.rx_data     = d;
        bus.pop         = p;
        bus.flush       = f;
        bus.clr_overrun = c;
        model_step(av, d, p, f, c);
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Receiver presents a byte; it stays visible through the ack cycle, then drops.
    task automatic send(input logic [7:0] b, input logic p);
        cycle(1'b1, b, p, 1'b0, 1'b0);
        chk("ack_pulse", 32'(bus.rx_ack), 32'd1);
        cycle(1'b1, b, 1'b0, 1'b0, 1'b0);
        chk("ack_single", 32'(bus.rx_ack), 32'd0);
    endtask

    task automatic pop_chk(input logic [7:0] exp);
        chk("pop_order", 32'(bus.rd_data), 32'(exp));
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bit         ravail;
        logic [7:0] rdat;
        bit         ack_seen;
        bit         p;

        bus.rx_avail    = 1'b0;
        bus.rx_data     = 8'h00;
        bus.pop         = 1'b0;
        bus.flush       = 1'b0;
        bus.clr_overrun = 1'b0;

        // Power-on reset
        #1;
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_non_empty", 32'(bus.non_empty), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_rx_ack", 32'(bus.rx_ack), 32'd0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: single capture, pop on empty, push after empty pop
        tbl[0] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h5A, 1'b0};
        tbl[1] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h5A, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h31, 1'b0};
        tbl[5] = '{1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h31, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b0, 8'h31, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].av, tbl[i].d, tbl[i].p, tbl[i].f, tbl[i].c);
            chk($sformatf("tbl%0d_level", i), 32'(bus.level), 32'(tbl[i].e_lvl));
            chk($sformatf("tbl%0d_ack", i), 32'(bus.rx_ack), 32'(tbl[i].e_ack));
            chk($sformatf("tbl%0d_rd", i), 32'(bus.rd_data), 32'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_ovr", i), 32'(bus.overrun), 32'(tbl[i].e_ovr));
        end

        // Fill to full, then one byte too many
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        send(8'hAA, 1'b0);
        chk("full_flag", 32'(bus.full), 32'd1);
        chk("full_level", 32'(bus.level), 32'd16);
        chk("full_overrun", 32'(bus.overrun), 32'd1);
        for (int i = 0; i < 16; i++) pop_chk(8'(i));

        // Asynchronous reset mid-operation (level 5, overrun still set)
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1'b0);
        chk("pre_rst_level", 32'(bus.level), 32'd5);
        chk("pre_rst_ovr", 32'(bus.overrun), 32'd1);
        bus.rx_avail = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_level", 32'(bus.level), 32'd0);
        chk("arst_non_empty", 32'(bus.non_empty), 32'd0);
        chk("arst_overrun", 32'(bus.overrun), 32'd0);
        chk("arst_rd_data", 32'(bus.rd_data), 32'd0);
        m_q.delete();
        m_ovr = 1'b0;
        m_ack = 1'b0;
        #2 rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Full FIFO: capture with simultaneous pop
        for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b0);
        send(8'h77, 1'b1);
        chk("fullpop_level", 32'(bus.level), 32'd16);
        chk("fullpop_ovr", 32'(bus.overrun), 32'd0);
        // Drop wins over same-cycle clear
        cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        chk("ovr_priority", 32'(bus.overrun), 32'd1);
        cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovr_clear", 32'(bus.overrun), 32'd0);
        for (int i = 1; i < 16; i++) pop_chk(8'(8'h20 + i));
        pop_chk(8'h77);
        chk("drain_level", 32'(bus.level), 32'd0);

        // Flush with simultaneous capture and pop at level 8, overrun set
        for (int i = 0; i < 17; i++) send(8'(8'h50 + i), 1'b0);
        for (int i = 0; i < 8; i++) pop_chk(8'(8'h50 + i));
        chk("preflush_level", 32'(bus.level), 32'd8);
        chk("preflush_ovr", 32'(bus.overrun), 32'd1);
        chk("preflush_half", 32'(bus.half_full), 32'd1);
        cycle(1'b1, 8'h44, 1'b1, 1'b1, 1'b0);
        chk("flush_level", 32'(bus.level), 32'd0);
        chk("flush_ovr", 32'(bus.overrun), 32'd0);
        chk("flush_half", 32'(bus.half_full), 32'd0);
        chk("flush_ack", 32'(bus.rx_ack), 32'd1);
        cycle(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        chk("flush_no_store", 32'(bus.non_empty), 32'd0);
        chk("flush_rd", 32'(bus.rd_data), 32'd0);
        send(8'h45, 1'b0);
        pop_chk(8'h45);

        // Randomized receiver and CPU against the model
        ravail = 1'b0;
        rdat   = 8'h00;
        for (int i = 0; i < 800; i++) begin
            if (!ravail && $urandom_range(0, 2) == 0) begin
                ravail = 1'b1;
                rdat   = 8'($urandom);
            end
            p = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ack_seen = bus.rx_ack;
            cycle(ravail, rdat, p, ($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0));
            if (ack_seen) ravail = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
